// File: rtl/accum_sched.sv
// Round-robin scheduler sharing one 8-bit accumulator between NREQ burst requesters.
// Build option: define ACCUM_SCHED_SAT_EN to saturate result on overflow.
module accum_sched #(
  parameter int NREQ  = 2,
  parameter int LEN_W = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*LEN_W-1:0]   len,
  input  logic [NREQ*8-1:0]       op_data,
  input  logic [NREQ-1:0]         op_valid,
  output logic [NREQ-1:0]         op_ready,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         done,
  output logic [7:0]              result,
  output logic                    result_ovf,
  output logic                    acc_clr,
  output logic                    acc_en,
  output logic [7:0]              acc_data,
  input  logic [7:0]              acc_sum,
  input  logic                    acc_ovf,
  output logic [2:0]              dbg_state
);

  localparam int IW = (NREQ > 2) ? 2 : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_STREAM = 3'd2,
    S_WAIT   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     owner_q, owner_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic              ovf_seen_q, ovf_seen_d;
  logic              en_prev_q, en_prev_d;
  logic [7:0]        result_q, result_d;
  logic              result_ovf_q, result_ovf_d;
`ifdef ACCUM_SCHED_SAT_EN
  logic              sign_prev_q, sign_prev_d;
  logic              ovf_sign_q, ovf_sign_d;
  logic              fin_sign;
`endif

  logic              arb_hit;
  logic [IW-1:0]     arb_idx;
  logic [IW-1:0]     cand_idx;
  int                cand;
  logic [NREQ-1:0]   owner_oh;
  logic              own_valid;
  logic [7:0]        own_data;
  logic              ovf_now;

  // Search upward from ptr+1 with wrap; the last owner therefore has lowest priority.
  always_comb begin
    arb_hit  = 1'b0;
    arb_idx  = '0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      cand_idx = IW'(cand);
      if (!arb_hit && req[cand_idx]) begin
        arb_hit = 1'b1;
        arb_idx = cand_idx;
      end
    end
  end

  always_comb begin
    owner_oh          = '0;
    owner_oh[owner_q] = 1'b1;
    own_valid         = op_valid[owner_q];
    own_data          = op_data[owner_q*8 +: 8];
  end

  // acc_ovf refers to the add enabled one cycle earlier; fold it in combinationally
  // so an operand arriving in that same cycle is already drained, not added.
  assign ovf_now = ovf_seen_q | (en_prev_q & acc_ovf);

  // Handshake: an operand transfers in a cycle where op_valid[i] and op_ready[i]
  // are both 1; op_ready is asserted only for the owner in STREAM and does not
  // depend on op_valid.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    ptr_d        = ptr_q;
    rem_d        = rem_q;
    ovf_seen_d   = ovf_seen_q;
    en_prev_d    = 1'b0;
    result_d     = result_q;
    result_ovf_d = result_ovf_q;
`ifdef ACCUM_SCHED_SAT_EN
    sign_prev_d  = sign_prev_q;
    ovf_sign_d   = ovf_sign_q;
    fin_sign     = ovf_seen_q ? ovf_sign_q : sign_prev_q;
`endif
    op_ready     = '0;
    gnt          = '0;
    done         = '0;
    acc_clr      = 1'b0;
    acc_en       = 1'b0;
    acc_data     = '0;

    case (state_q)
      S_IDLE: begin
        if (arb_hit) begin
          owner_d    = arb_idx;
          rem_d      = len[arb_idx*LEN_W +: LEN_W];
          ovf_seen_d = 1'b0;
          state_d    = S_CLEAR;
        end
      end
      S_CLEAR: begin
        gnt     = owner_oh;
        acc_clr = 1'b1;
        if (rem_q == '0) begin
          result_d     = '0;
          result_ovf_d = 1'b0;
          state_d      = S_DONE;
        end else begin
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        gnt        = owner_oh;
        op_ready   = owner_oh;
        ovf_seen_d = ovf_now;
`ifdef ACCUM_SCHED_SAT_EN
        if (!ovf_seen_q && en_prev_q && acc_ovf) ovf_sign_d = sign_prev_q;
`endif
        if (own_valid) begin
          acc_data  = own_data;
          acc_en    = !ovf_now;
          en_prev_d = !ovf_now;
`ifdef ACCUM_SCHED_SAT_EN
          sign_prev_d = own_data[7];
`endif
          rem_d = rem_q - 1'b1;
          if (rem_q == LEN_W'(1)) state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        gnt          = owner_oh;
        ovf_seen_d   = ovf_now;
        result_ovf_d = ovf_now;
        result_d     = acc_sum;
`ifdef ACCUM_SCHED_SAT_EN
        ovf_sign_d = fin_sign;
        if (ovf_now) result_d = fin_sign ? 8'h80 : 8'h7F;
`endif
        state_d = S_DONE;
      end
      S_DONE: begin
        gnt     = owner_oh;
        done    = owner_oh;
        ptr_d   = owner_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      owner_q      <= '0;
      ptr_q        <= IW'(NREQ - 1);
      rem_q        <= '0;
      ovf_seen_q   <= 1'b0;
      en_prev_q    <= 1'b0;
      result_q     <= '0;
      result_ovf_q <= 1'b0;
`ifdef ACCUM_SCHED_SAT_EN
      sign_prev_q  <= 1'b0;
      ovf_sign_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      ptr_q        <= ptr_d;
      rem_q        <= rem_d;
      ovf_seen_q   <= ovf_seen_d;
      en_prev_q    <= en_prev_d;
      result_q     <= result_d;
      result_ovf_q <= result_ovf_d;
`ifdef ACCUM_SCHED_SAT_EN
      sign_prev_q  <= sign_prev_d;
      ovf_sign_q   <= ovf_sign_d;
`endif
    end
  end

  assign result     = (state_q == S_DONE) ? result_q : '0;
  assign result_ovf = (state_q == S_DONE) ? result_ovf_q : 1'b0;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_accum_sched.sv
// Directed bench for accum_sched with a behavioural accumulator attached.
module tb_accum_sched;
  localparam int NREQ  = 2;
  localparam int LEN_W = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ*LEN_W-1:0] len;
  logic [NREQ*8-1:0]     op_data;
  logic [NREQ-1:0]       op_valid;
  logic [NREQ-1:0]       op_ready;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       done;
  logic [7:0]            result;
  logic                  result_ovf;
  logic                  acc_clr;
  logic                  acc_en;
  logic [7:0]            acc_data;
  logic [7:0]            acc_sum;
  logic                  acc_ovf;
  logic [2:0]            dbg_state;

  int errors = 0;
  int checks = 0;

  accum_sched #(.NREQ(NREQ), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .req(req), .len(len), .op_data(op_data),
    .op_valid(op_valid), .op_ready(op_ready), .gnt(gnt), .done(done),
    .result(result), .result_ovf(result_ovf), .acc_clr(acc_clr),
    .acc_en(acc_en), .acc_data(acc_data), .acc_sum(acc_sum),
    .acc_ovf(acc_ovf), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Accumulator: sum updates one cycle after acc_en, overflow flag alongside it.
  logic [7:0] m_sum = 8'h00;
  logic       m_ovf = 1'b0;
  logic [7:0] m_next;
  assign m_next  = m_sum + acc_data;
  assign acc_sum = m_sum;
  assign acc_ovf = m_ovf;
  always @(posedge clk) begin
    if (acc_clr) begin
      m_sum <= 8'h00;
      m_ovf <= 1'b0;
    end else if (acc_en) begin
      m_sum <= m_next;
      m_ovf <= (m_sum[7] == acc_data[7]) && (m_next[7] != m_sum[7]);
    end else begin
      m_ovf <= 1'b0;
    end
  end

  // Results of the last drive_burst call.
  logic [7:0]      ops_tb [0:15];
  int              d_clr, d_en, d_en_nohs, d_data_bad, d_done_cyc, d_gnt_bad, d_ready_drop;
  logic [7:0]      d_res;
  logic            d_ovf, d_acc_ovf_seen;
  logic [NREQ-1:0] d_done_vec;
  logic            d_en_at [0:15];

  task automatic drive_burst(input int r, input int n, input int gap);
    int  k, stall;
    bit  hs, rdy_seen;
    k = 0; stall = gap; rdy_seen = 0;
    d_clr = 0; d_en = 0; d_en_nohs = 0; d_data_bad = 0; d_done_cyc = -1;
    d_gnt_bad = 0; d_ready_drop = 0; d_res = 8'hxx; d_ovf = 1'bx;
    d_acc_ovf_seen = 0; d_done_vec = '0;
    for (int i = 0; i < 16; i++) d_en_at[i] = 1'b0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      req[r]                  = 1'b1;
      len[r*LEN_W +: LEN_W]   = LEN_W'(n);
      op_valid[r]             = (k < n) && (stall == 0);
      op_data[r*8 +: 8]       = (k < n) ? ops_tb[k] : 8'h00;
      #1;
      if (acc_clr) d_clr++;
      if (acc_en) d_en++;
      if (acc_ovf) d_acc_ovf_seen = 1'b1;
      if (gnt != '0 && gnt != NREQ'(1 << r)) d_gnt_bad++;
      if (op_ready[r]) rdy_seen = 1;
      if (rdy_seen && k < n && !op_ready[r]) d_ready_drop++;
      hs = op_valid[r] && op_ready[r];
      if (acc_en && !hs) d_en_nohs++;
      if (acc_en && acc_data !== ops_tb[k]) d_data_bad++;
      if (hs) begin
        d_en_at[k] = acc_en;
        k++;
        stall = gap;
      end else if (!op_valid[r] && stall > 0) begin
        stall--;
      end
      if (done != '0) begin
        d_done_cyc = cyc;
        d_done_vec = done;
        d_res      = result;
        d_ovf      = result_ovf;
        req[r]      = 1'b0;
        op_valid[r] = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; req = '0; len = '0; op_data = '0; op_valid = '0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({gnt, op_ready, done, acc_clr, acc_en, acc_data, result, result_ovf} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %0h required 0",
               {gnt, op_ready, done, acc_clr, acc_en, acc_data, result, result_ovf});
    end
    checks++;
    if (dbg_state !== 3'd0) begin
      errors++;
      $display("FAIL reset_state: got %0d required 0", dbg_state);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] dn [0:3];
    logic [7:0]      rs [0:3];
    logic [NREQ-1:0] exp_dn [0:3];
    int cnt;
    exp_dn[0] = 2'b01; exp_dn[1] = 2'b10; exp_dn[2] = 2'b01; exp_dn[3] = 2'b10;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin dn[i] = '0; rs[i] = 8'hxx; end
    for (int cyc = 0; cyc < 60 && cnt < 4; cyc++) begin
      @(negedge clk);
      req = 2'b11; len = {4'd1, 4'd1}; op_valid = 2'b11; op_data = {8'd1, 8'd1};
      #1;
      if (done != '0) begin
        dn[cnt] = done;
        rs[cnt] = result;
        cnt++;
        if (cnt == 4) begin req = '0; op_valid = '0; end
      end
    end
    req = '0; op_valid = '0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (dn[i] !== exp_dn[i]) begin
        errors++;
        $display("FAIL rr_owner%0d: got %b required %b", i, dn[i], exp_dn[i]);
      end
      checks++;
      if (rs[i] !== 8'd1) begin
        errors++;
        $display("FAIL rr_result%0d: got %0h required 01", i, rs[i]);
      end
    end
  endtask

  task automatic test_single();
    ops_tb[0] = 8'd10; ops_tb[1] = 8'd20; ops_tb[2] = 8'hFB;
    drive_burst(0, 3, 0);
    checks++;
    if (d_done_vec !== 2'b01) begin errors++; $display("FAIL single_done: got %b required 01", d_done_vec); end
    checks++;
    if (d_done_cyc !== 6) begin errors++; $display("FAIL single_latency: got %0d required 6", d_done_cyc); end
    checks++;
    if (d_res !== 8'd25 || d_ovf !== 1'b0) begin
      errors++; $display("FAIL single_result: got %0h/%b required 19/0", d_res, d_ovf);
    end
    checks++;
    if (d_clr !== 1 || d_en !== 3) begin
      errors++; $display("FAIL single_ctrl: got clr=%0d en=%0d required clr=1 en=3", d_clr, d_en);
    end
    checks++;
    if (d_gnt_bad !== 0 || d_data_bad !== 0) begin
      errors++; $display("FAIL single_gnt_data: got gnt_bad=%0d data_bad=%0d required 0/0", d_gnt_bad, d_data_bad);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] exp_res;
`ifdef ACCUM_SCHED_SAT_EN
    exp_res = 8'h7F;
`else
    exp_res = 8'h96;
`endif
    ops_tb[0] = 8'd100; ops_tb[1] = 8'd50; ops_tb[2] = 8'd3; ops_tb[3] = 8'd4;
    drive_burst(0, 4, 0);
    checks++;
    if ({d_en_at[0], d_en_at[1], d_en_at[2], d_en_at[3]} !== 4'b1100) begin
      errors++;
      $display("FAIL ovf_drain_en: got %b required 1100", {d_en_at[0], d_en_at[1], d_en_at[2], d_en_at[3]});
    end
    checks++;
    if (d_acc_ovf_seen !== 1'b1) begin errors++; $display("FAIL ovf_acc_flag: got 0 required 1"); end
    checks++;
    if (d_ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b required 1", d_ovf); end
    checks++;
    if (d_res !== exp_res) begin errors++; $display("FAIL ovf_result: got %0h required %0h", d_res, exp_res); end
  endtask

  task automatic test_zero_len();
    drive_burst(1, 0, 0);
    checks++;
    if (d_done_vec !== 2'b10 || d_done_cyc !== 2) begin
      errors++; $display("FAIL zero_done: got %b@%0d required 10@2", d_done_vec, d_done_cyc);
    end
    checks++;
    if (d_res !== 8'd0 || d_ovf !== 1'b0) begin
      errors++; $display("FAIL zero_result: got %0h/%b required 0/0", d_res, d_ovf);
    end
    checks++;
    if (d_clr !== 1 || d_en !== 0) begin
      errors++; $display("FAIL zero_ctrl: got clr=%0d en=%0d required 1/0", d_clr, d_en);
    end
  endtask

  task automatic test_stall();
    ops_tb[0] = 8'd7; ops_tb[1] = 8'hFD;
    drive_burst(0, 2, 3);
    checks++;
    if (d_res !== 8'd4 || d_ovf !== 1'b0) begin
      errors++; $display("FAIL stall_result: got %0h/%b required 04/0", d_res, d_ovf);
    end
    checks++;
    if (d_en !== 2 || d_en_nohs !== 0) begin
      errors++; $display("FAIL stall_en: got en=%0d en_nohs=%0d required 2/0", d_en, d_en_nohs);
    end
    checks++;
    if (d_ready_drop !== 0) begin errors++; $display("FAIL stall_ready: got drops=%0d required 0", d_ready_drop); end
    checks++;
    if (d_done_cyc !== 9) begin errors++; $display("FAIL stall_latency: got %0d required 9", d_done_cyc); end
  endtask

  task automatic test_reset_mid();
    bit got_hs, done_in_rst;
    logic [NREQ-1:0] first_done;
    got_hs = 0; done_in_rst = 0; first_done = '0;
    for (int cyc = 0; cyc < 10 && !got_hs; cyc++) begin
      @(negedge clk);
      req = 2'b01; len = {4'd0, 4'd3}; op_valid = 2'b01; op_data = {8'd0, 8'd5};
      #1;
      if (op_valid[0] && op_ready[0]) got_hs = 1;
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (!got_hs || {gnt, op_ready, done, acc_clr, acc_en, acc_data, result, result_ovf} !== '0) begin
      errors++;
      $display("FAIL midrst_outputs: hs=%0d got %0h required 0", got_hs,
               {gnt, op_ready, done, acc_clr, acc_en, acc_data, result, result_ovf});
    end
    req = '0; op_valid = '0;
    repeat (2) begin
      @(negedge clk);
      #1;
      if (done != '0) done_in_rst = 1;
    end
    rst = 1'b1;
    for (int cyc = 0; cyc < 20 && first_done == '0; cyc++) begin
      @(negedge clk);
      req = 2'b11; len = {4'd1, 4'd1}; op_valid = 2'b11; op_data = {8'd1, 8'd1};
      #1;
      if (done != '0) begin
        first_done = done;
        req = '0; op_valid = '0;
      end
    end
    checks++;
    if (done_in_rst) begin errors++; $display("FAIL midrst_nodone: got 1 required 0"); end
    checks++;
    if (first_done !== 2'b01) begin errors++; $display("FAIL midrst_priority: got %b required 01", first_done); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_overflow();
    test_zero_len();
    test_stall();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
